// File: rtl/datapath_seq_if.sv
// Control/datapath bundle for datapath_seq: register selects, ALU and
// sequential-unit handshake, memory data and observability outputs.
interface datapath_seq_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    logic [NREGS-1:0] Rin;
    logic [NREGS-1:0] Rout;
    logic             PCin;
    logic             PCout;
    logic             IRin;
    logic             Yin;
    logic             MDRin;
    logic             MDRout;
    logic             HIin;
    logic             HIout;
    logic             LOin;
    logic             LOout;
    logic             Zin;
    logic             Zhighout;
    logic             Zlowout;
    logic             Read;
    logic [WIDTH-1:0] Mdatain;
    logic [3:0]       ALUop;
    logic             mul_start;
    logic             div_start;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             bus_conflict;
    logic [WIDTH-1:0] BusMuxOut;
    logic [WIDTH-1:0] IR_q;

    modport master (
        output Rin, Rout, PCin, PCout, IRin, Yin,
        output MDRin, MDRout, HIin, HIout, LOin, LOout,
        output Zin, Zhighout, Zlowout, Read, Mdatain,
        output ALUop, mul_start, div_start,
        input  busy, done, div_by_zero, bus_conflict,
        input  BusMuxOut, IR_q
    );

    modport slave (
        input  Rin, Rout, PCin, PCout, IRin, Yin,
        input  MDRin, MDRout, HIin, HIout, LOin, LOout,
        input  Zin, Zhighout, Zlowout, Read, Mdatain,
        input  ALUop, mul_start, div_start,
        output busy, done, div_by_zero, bus_conflict,
        output BusMuxOut, IR_q
    );
endinterface

// File: rtl/datapath_seq.sv
// Single-bus datapath with priority bus mux, ALU into Z and a sequential
// signed multiply (Booth) / divide (restoring) unit that owns Z while running.
module datapath_seq #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input logic          clock,
    input logic          clear,
    datapath_seq_if.slave dp
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [WIDTH-1:0]   r [NREGS];
    logic [WIDTH-1:0]   pc, ir, y, mdr, hi, lo;
    logic [2*WIDTH-1:0] z;
    logic [WIDTH-1:0]   bus, alu;
    logic [NREGS+5:0]   sel;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic             is_mul, accept, fin;
    logic [WIDTH:0]   acc, acc_n;
    logic [WIDTH-1:0] qr, qr_n;
    logic             qm1, qm1_n;
    logic [WIDTH-1:0] mcand, dvd;
    logic             neg_q, neg_r, dz, dbz;
    logic [2*WIDTH-1:0] seq_res;

    // Lowest priority first so higher-priority drivers override
    always_comb begin
        bus = '0;
        if (dp.Zlowout)  bus = z[WIDTH-1:0];
        if (dp.Zhighout) bus = z[2*WIDTH-1:WIDTH];
        if (dp.LOout)    bus = lo;
        if (dp.HIout)    bus = hi;
        if (dp.MDRout)   bus = mdr;
        if (dp.PCout)    bus = pc;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (dp.Rout[i]) bus = r[i];
        end
    end

    assign sel = {dp.Rout, dp.PCout, dp.MDRout, dp.HIout,
                  dp.LOout, dp.Zhighout, dp.Zlowout};

    assign dp.BusMuxOut    = bus;
    assign dp.bus_conflict = ($countones(sel) > 1);
    assign dp.IR_q         = ir;
    assign dp.busy         = (state == RUN);
    assign dp.div_by_zero  = dbz;

    logic [SW-1:0]      sh;
    logic [2*WIDTH-1:0] dbl_r, dbl_l;

    always_comb begin
        sh    = bus[SW-1:0];
        dbl_r = {y, y} >> sh;
        dbl_l = {y, y} << sh;
        case (dp.ALUop)
            4'd0:    alu = y + bus;
            4'd1:    alu = y - bus;
            4'd2:    alu = y & bus;
            4'd3:    alu = y | bus;
            4'd4:    alu = y >> sh;
            4'd5:    alu = $signed(y) >>> sh;
            4'd6:    alu = y << sh;
            4'd7:    alu = dbl_r[WIDTH-1:0];
            4'd8:    alu = dbl_l[2*WIDTH-1:WIDTH];
            4'd9:    alu = '0 - bus;
            4'd10:   alu = ~bus;
            default: alu = '0;
        endcase
    end

    logic [WIDTH:0] sum, r2, trial;
    logic [WIDTH-1:0] quo, rem;

    always_comb begin
        sum   = acc;
        r2    = {acc[WIDTH-1:0], qr[WIDTH-1]};
        trial = r2 - {1'b0, mcand};
        qm1_n = qm1;
        if (is_mul) begin
            if ({qr[0], qm1} == 2'b01) sum = acc + {mcand[WIDTH-1], mcand};
            if ({qr[0], qm1} == 2'b10) sum = acc - {mcand[WIDTH-1], mcand};
            acc_n = {sum[WIDTH], sum[WIDTH:1]};
            qr_n  = {sum[0], qr[WIDTH-1:1]};
            qm1_n = qr[0];
        end else if (!trial[WIDTH]) begin
            acc_n = trial;
            qr_n  = {qr[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = r2;
            qr_n  = {qr[WIDTH-2:0], 1'b0};
        end
        quo = neg_q ? ('0 - qr_n) : qr_n;
        rem = neg_r ? ('0 - acc_n[WIDTH-1:0]) : acc_n[WIDTH-1:0];
        if (is_mul)  seq_res = {acc_n[WIDTH-1:0], qr_n};
        else if (dz) seq_res = {dvd, {WIDTH{1'b1}}};
        else         seq_res = {rem, quo};
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (dp.mul_start || dp.div_start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    fin     = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_n;
    end

    logic [WIDTH-1:0] ya, ba;
    assign ya = y[WIDTH-1]   ? ('0 - y)   : y;
    assign ba = bus[WIDTH-1] ? ('0 - bus) : bus;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt     <= '0;
            is_mul  <= 1'b0;
            acc     <= '0;
            qr      <= '0;
            qm1     <= 1'b0;
            mcand   <= '0;
            dvd     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            dbz     <= 1'b0;
            dp.done <= 1'b0;
        end else begin
            dp.done <= fin;
            if (accept) begin
                cnt    <= CW'(WIDTH);
                is_mul <= dp.mul_start;
                acc    <= '0;
                qm1    <= 1'b0;
                dvd    <= y;
                neg_q  <= y[WIDTH-1] ^ bus[WIDTH-1];
                neg_r  <= y[WIDTH-1];
                dz     <= (bus == '0);
                dbz    <= 1'b0;
                qr     <= dp.mul_start ? bus : ya;
                mcand  <= dp.mul_start ? y : ba;
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
                acc <= acc_n;
                qr  <= qr_n;
                qm1 <= qm1_n;
                if (fin && !is_mul && dz) dbz <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) r[i] <= '0;
            pc  <= '0;
            ir  <= '0;
            y   <= '0;
            mdr <= '0;
            hi  <= '0;
            lo  <= '0;
            z   <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (dp.Rin[i]) r[i] <= bus;
            end
            if (dp.PCin)  pc  <= bus;
            if (dp.IRin)  ir  <= bus;
            if (dp.Yin)   y   <= bus;
            if (dp.HIin)  hi  <= bus;
            if (dp.LOin)  lo  <= bus;
            if (dp.MDRin) mdr <= dp.Read ? dp.Mdatain : bus;
            if (fin)
                z <= seq_res;
            else if (dp.Zin && state == IDLE)
                z <= {{WIDTH{1'b0}}, alu};
        end
    end
endmodule

// File: tb/tb_datapath_seq.sv
// Directed self-checking bench for datapath_seq (WIDTH=32, NREGS=16).
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_datapath_seq;
    localparam int W = 32;
    localparam int N = 16;

    logic clock = 1'b0;
    logic clear;
    int   n_run  = 0;
    int   n_fail = 0;

    datapath_seq_if #(.WIDTH(W), .NREGS(N)) dpi ();

    datapath_seq #(.WIDTH(W), .NREGS(N)) dut (
        .clock(clock),
        .clear(clear),
        .dp   (dpi)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        dpi.Rin = '0;      dpi.Rout = '0;
        dpi.PCin = 0;      dpi.PCout = 0;
        dpi.IRin = 0;      dpi.Yin = 0;
        dpi.MDRin = 0;     dpi.MDRout = 0;
        dpi.HIin = 0;      dpi.HIout = 0;
        dpi.LOin = 0;      dpi.LOout = 0;
        dpi.Zin = 0;       dpi.Zhighout = 0;
        dpi.Zlowout = 0;   dpi.Read = 0;
        dpi.Mdatain = '0;  dpi.ALUop = '0;
        dpi.mul_start = 0; dpi.div_start = 0;
    endtask

    task automatic mdr_load(input logic [W-1:0] v);
        idle;
        dpi.Read = 1; dpi.Mdatain = v; dpi.MDRin = 1;
        tick;
        idle;
    endtask

    task automatic set_reg(input int i, input logic [W-1:0] v);
        mdr_load(v);
        dpi.MDRout = 1; dpi.Rin[i] = 1;
        tick;
        idle;
    endtask

    task automatic set_y(input logic [W-1:0] v);
        mdr_load(v);
        dpi.MDRout = 1; dpi.Yin = 1;
        tick;
        idle;
    endtask

    task automatic read_z(output logic [63:0] zv);
        idle;
        dpi.Zhighout = 1;
        #1 zv[63:32] = dpi.BusMuxOut;
        dpi.Zhighout = 0; dpi.Zlowout = 1;
        #1 zv[31:0] = dpi.BusMuxOut;
        idle;
        #1;
    endtask

    task automatic alu_chk(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [3:0] op,
                           input logic [W-1:0] e);
        logic [63:0] zv;
        set_y(a);
        mdr_load(b);
        dpi.MDRout = 1; dpi.ALUop = op; dpi.Zin = 1;
        tick;
        read_z(zv);
        check(tag, zv, {32'h0, e});
    endtask

    task automatic run_seq(input bit mul, input logic [W-1:0] a,
                           input logic [W-1:0] b, output int done_at,
                           output int busy_n, output int done_n,
                           output logic dbz0);
        set_y(a);
        mdr_load(b);
        dpi.MDRout = 1;
        dpi.mul_start = mul;
        dpi.div_start = !mul;
        tick;
        idle;
        busy_n  = int'(dpi.busy);
        dbz0    = dpi.div_by_zero;
        done_at = 0;
        done_n  = 0;
        for (int n = 1; n <= 40; n++) begin
            if (mul && n == 10) begin
                dpi.MDRout = 1; dpi.mul_start = 1;
            end
            tick;
            idle;
            if (dpi.busy) busy_n++;
            if (dpi.done) begin
                done_n++;
                if (done_at == 0) done_at = n;
            end
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic [W-1:0] e;
    } vec_t;

    vec_t alu_tbl [13] = '{
        '{32'h000000F1, 32'h4,        4'd7,  32'h1000000F},
        '{32'h00000005, 32'h7,        4'd1,  32'hFFFFFFFE},
        '{32'h0000F0F0, 32'hFF00,     4'd2,  32'h0000F000},
        '{32'h0000F0F0, 32'h0F0F,     4'd3,  32'h0000FFFF},
        '{32'h80000000, 32'h4,        4'd4,  32'h08000000},
        '{32'h80000000, 32'h4,        4'd5,  32'hF8000000},
        '{32'h80000001, 32'h1,        4'd6,  32'h00000002},
        '{32'h80000001, 32'h4,        4'd8,  32'h00000018},
        '{32'h00000000, 32'h5,        4'd9,  32'hFFFFFFFB},
        '{32'h00000000, 32'h0000FFFF, 4'd10, 32'hFFFF0000},
        '{32'h00000012, 32'h34,       4'd12, 32'h00000000},
        '{32'hFFFFFFFF, 32'h1,        4'd0,  32'h00000000},
        '{32'h00000081, 32'h24,       4'd4,  32'h00000008}
    };

    typedef struct {
        bit           mul;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [63:0]  e;
        logic         dbz;
    } seq_t;

    seq_t seq_tbl [7] = '{
        '{1'b1, 32'hFFFFFFF9, 32'h6,        64'hFFFFFFFF_FFFFFFD6, 1'b0},
        '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0},
        '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 1'b0},
        '{1'b0, 32'hFFFFFFEF, 32'h5,        64'hFFFFFFFE_FFFFFFFD, 1'b0},
        '{1'b0, 32'd100,      32'h0,        64'h00000064_FFFFFFFF, 1'b1},
        '{1'b0, 32'd6,        32'd3,        64'h00000000_00000002, 1'b0},
        '{1'b0, 32'd17,       32'hFFFFFFFB, 64'h00000002_FFFFFFFD, 1'b0}
    };

    initial begin
        logic [63:0] zv;
        int          done_at, busy_n, done_n;
        logic        dbz0;
        bit          saw_done;

        idle;
        clear = 1;
        tick;
        tick;
        clear = 0;
        #1;
        check("rst_bus",      {32'h0, dpi.BusMuxOut}, 64'h0);
        check("rst_busy",     {63'h0, dpi.busy}, 64'h0);
        check("rst_done",     {63'h0, dpi.done}, 64'h0);
        check("rst_dbz",      {63'h0, dpi.div_by_zero}, 64'h0);
        check("rst_conflict", {63'h0, dpi.bus_conflict}, 64'h0);
        check("rst_ir",       {32'h0, dpi.IR_q}, 64'h0);
        read_z(zv);
        check("rst_z", zv, 64'h0);

        mdr_load(32'h12);
        dpi.MDRout = 1; dpi.Rin[3] = 1;
        tick;
        idle;
        dpi.Rout[3] = 1;
        #1;
        check("mem_r3",       {32'h0, dpi.BusMuxOut}, 64'h12);
        check("mem_conflict", {63'h0, dpi.bus_conflict}, 64'h0);
        idle;

        set_reg(2, 32'h34);
        set_reg(4, 32'h45);
        dpi.Rout[2] = 1; dpi.Yin = 1;
        tick;
        idle;
        dpi.Rout[4] = 1; dpi.ALUop = 4'd0; dpi.Zin = 1;
        tick;
        read_z(zv);
        check("alu_add_regs", zv, 64'h79);

        foreach (alu_tbl[i])
            alu_chk($sformatf("alu_%0d_op%0d", i, alu_tbl[i].op),
                    alu_tbl[i].a, alu_tbl[i].b, alu_tbl[i].op, alu_tbl[i].e);

        mdr_load(32'hDEADBEEF);
        dpi.MDRout = 1; dpi.IRin = 1; dpi.HIin = 1;
        tick;
        idle;
        check("ir_load", {32'h0, dpi.IR_q}, 64'hDEADBEEF);
        dpi.HIout = 1;
        #1;
        check("hi_load", {32'h0, dpi.BusMuxOut}, 64'hDEADBEEF);
        idle;

        set_reg(1, 32'hA);
        mdr_load(32'hB);
        dpi.MDRout = 1; dpi.PCin = 1;
        tick;
        idle;
        dpi.Rout[1] = 1; dpi.PCout = 1;
        #1;
        check("conf_bus", {32'h0, dpi.BusMuxOut}, 64'hA);
        check("conf_on",  {63'h0, dpi.bus_conflict}, 64'h1);
        dpi.PCout = 0;
        #1;
        check("conf_off", {63'h0, dpi.bus_conflict}, 64'h0);
        dpi.Rout[1] = 0; dpi.PCout = 1;
        #1;
        check("pc_bus", {32'h0, dpi.BusMuxOut}, 64'hB);
        idle;

        foreach (seq_tbl[i]) begin
            run_seq(seq_tbl[i].mul, seq_tbl[i].a, seq_tbl[i].b,
                    done_at, busy_n, done_n, dbz0);
            check($sformatf("seq%0d_done_at", i), 64'(done_at), 64'd32);
            check($sformatf("seq%0d_busy_n", i), 64'(busy_n), 64'd32);
            check($sformatf("seq%0d_done_n", i), 64'(done_n), 64'd1);
            check($sformatf("seq%0d_dbz_start", i), {63'h0, dbz0}, 64'h0);
            check($sformatf("seq%0d_dbz", i),
                  {63'h0, dpi.div_by_zero}, {63'h0, seq_tbl[i].dbz});
            read_z(zv);
            check($sformatf("seq%0d_z", i), zv, seq_tbl[i].e);
        end

        set_y(32'hFFFFFFF9);
        mdr_load(32'h6);
        dpi.MDRout = 1; dpi.mul_start = 1;
        tick;
        idle;
        for (int n = 0; n < 10; n++) tick;
        clear = 1;
        #1;
        check("abort_busy", {63'h0, dpi.busy}, 64'h0);
        saw_done = 0;
        for (int n = 0; n < 3; n++) begin
            tick;
            if (dpi.done) saw_done = 1;
        end
        clear = 0;
        for (int n = 0; n < 40; n++) begin
            tick;
            if (dpi.done) saw_done = 1;
        end
        check("abort_no_done", {63'h0, saw_done}, 64'h0);
        read_z(zv);
        check("abort_z", zv, 64'h0);
        dpi.Rout[3] = 1;
        #1;
        check("abort_r3", {32'h0, dpi.BusMuxOut}, 64'h0);
        idle;
        dpi.PCout = 1;
        #1;
        check("abort_pc", {32'h0, dpi.BusMuxOut}, 64'h0);
        idle;
        check("abort_ir", {32'h0, dpi.IR_q}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
